// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] STOP_WORD = 32'h0000_0000;
  localparam logic [2:0] FUNCT3_WORD = 3'b010;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = {{(XLEN - 2){1'b1}}, 2'b00};

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  // Number of bits needed to hold an occupancy value 0..depth inclusive.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of fetch entries; flush empties it in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  fetch_entry_t                     push_data,
  input  logic                             pop,
  input  logic                             flush,
  output fetch_entry_t                     head,
  output logic [occ_width(DEPTH)-1:0]      count,
  output logic                             empty,
  output logic                             full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = occ_width(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push_c;
  logic             do_pop_c;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign head      = mem_q[rd_ptr_q];
  assign do_pop_c  = pop && !empty;
  assign do_push_c = push && (!full || do_pop_c);

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_c) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
    end
  end

  push_when_full_a : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && full && !pop));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues word reads, buffers responses with their PCs,
// handles redirects and halts on the all-zero stop word.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] mem_read_address,
  output logic [2:0]      mem_funct3,
  input  logic [XLEN-1:0] mem_read_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            halted
);

  localparam int unsigned CNT_W = occ_width(FIFO_DEPTH);
  localparam int unsigned OCC_W = CNT_W + 1;

  fetch_state_t     state_q;
  logic [XLEN-1:0]  fetch_pc_q;
  logic [XLEN-1:0]  inflight_pc_q;
  logic             inflight_q;

  fetch_entry_t     head;
  fetch_entry_t     push_data;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             fifo_full;

  logic             pop_c;
  logic             resp_c;
  logic             stop_c;
  logic             push_c;
  logic             room_c;
  logic             issue_c;
  logic [OCC_W-1:0] occ_c;

  assign mem_read_address = fetch_pc_q;
  assign mem_funct3       = FUNCT3_WORD;
  assign instr_valid      = !fifo_empty;
  assign instr            = head.instr;
  assign instr_pc         = head.pc;

  // A redirect squashes the response arriving in the same cycle.
  assign pop_c  = instr_valid && instr_ready;
  assign resp_c = inflight_q && !redirect_valid;
  assign stop_c = resp_c && (mem_read_data == STOP_WORD);
  assign push_c = resp_c && (mem_read_data != STOP_WORD);

  assign push_data.pc    = inflight_pc_q;
  assign push_data.instr = mem_read_data;

  // Buffered plus in-flight entries must still fit after this cycle's pop.
  assign occ_c   = OCC_W'(fifo_count) + OCC_W'(inflight_q);
  assign room_c  = (fifo_full && !pop_c) ? 1'b0
                 : ((occ_c - OCC_W'(pop_c)) < OCC_W'(FIFO_DEPTH));
  assign issue_c = (state_q == RUN) && !redirect_valid && !stop_c && room_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      halted        <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (redirect_valid) begin
      state_q    <= RUN;
      halted     <= 1'b0;
      fetch_pc_q <= redirect_pc & PC_ALIGN_MASK;
      inflight_q <= 1'b0;
    end else begin
      if (stop_c) begin
        state_q <= HALT;
        halted  <= 1'b1;
      end
      inflight_q <= issue_c;
      if (issue_c) begin
        inflight_pc_q <= fetch_pc_q;
        fetch_pc_q    <= fetch_pc_q + XLEN'(4);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_data (push_data),
    .pop       (pop_c),
    .flush     (redirect_valid),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a latency-1 word memory model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_read_address;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_read_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        halted;

  logic [31:0] prog [0:127];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_read_address (mem_read_address),
    .mem_funct3       (mem_funct3),
    .mem_read_data    (mem_read_data),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .halted           (halted)
  );

  // Registered read: data for the address seen at this edge appears after it.
  always @(posedge clk) mem_read_data <= prog[mem_read_address[8:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;
    mem_read_data  = '0;
    for (int i = 0; i < 128; i++) prog[i] = 32'h1300_0000 + 32'(i);
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h00A0_0113;

    // Reset values
    step();
    step();
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", instr_pc, 32'h0);
    check("rst_addr", mem_read_address, 32'h0);
    check("rst_halted", 32'(halted), 32'd0);
    check("funct3", 32'(mem_funct3), 32'd2);

    // Startup latency and streaming
    rst_n = 1'b1;
    step();
    check("e1_valid", 32'(instr_valid), 32'd0);
    check("e1_addr", mem_read_address, 32'h4);
    step();
    check("e2_valid", 32'(instr_valid), 32'd1);
    check("e2_instr", instr, 32'h0050_0093);
    check("e2_pc", instr_pc, 32'h0);
    step();
    check("e3_instr", instr, 32'h00A0_0113);
    check("e3_pc", instr_pc, 32'h4);
    step();
    check("e4_valid", 32'(instr_valid), 32'd1);
    check("e4_pc", instr_pc, 32'h8);

    // Asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(instr_valid), 32'd0);
    check("arst_instr", instr, 32'h0);
    check("arst_pc", instr_pc, 32'h0);
    check("arst_addr", mem_read_address, 32'h0);

    // Back-pressure: FIFO fills with PCs 0,4 and fetch stops at 8
    instr_ready = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("bp_valid", 32'(instr_valid), 32'd1);
    check("bp_pc", instr_pc, 32'h0);
    check("bp_instr", instr, 32'h0050_0093);
    check("bp_addr", mem_read_address, 32'h8);
    instr_ready = 1'b1;
    step();
    check("rel_pc4", instr_pc, 32'h4);
    step();
    check("rel_pc8", instr_pc, 32'h8);
    check("rel_ins8", instr, 32'h1300_0002);
    step();
    check("rel_pcC", instr_pc, 32'hC);
    check("rel_vC", 32'(instr_valid), 32'd1);
    step();
    check("rel_pc10", instr_pc, 32'h10);

    // Redirect with buffered entry and a fetch in flight
    instr_ready    = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    step();
    redirect_valid = 1'b0;
    check("rd_flush", 32'(instr_valid), 32'd0);
    check("rd_addr", mem_read_address, 32'h100);
    step();
    check("rd1_valid", 32'(instr_valid), 32'd0);
    check("rd1_addr", mem_read_address, 32'h104);
    step();
    check("rd2_valid", 32'(instr_valid), 32'd1);
    check("rd2_pc", instr_pc, 32'h100);
    check("rd2_instr", instr, 32'h1300_0040);
    step();
    check("rd3_hold", instr_pc, 32'h100);

    // Stop word at 0xC
    rst_n       = 1'b0;
    instr_ready = 1'b1;
    prog[3]     = 32'h0;
    step();
    rst_n = 1'b1;
    step();
    step();
    check("st_pc0", instr_pc, 32'h0);
    step();
    check("st_pc4", instr_pc, 32'h4);
    step();
    check("st_pc8", instr_pc, 32'h8);
    check("st_h0", 32'(halted), 32'd0);
    step();
    check("st_halted", 32'(halted), 32'd1);
    check("st_valid", 32'(instr_valid), 32'd0);
    check("st_addr", mem_read_address, 32'h10);
    for (int i = 0; i < 3; i++) step();
    check("st_hold_addr", mem_read_address, 32'h10);
    check("st_hold_valid", 32'(instr_valid), 32'd0);
    check("st_hold_h", 32'(halted), 32'd1);
    prog[3] = 32'h1300_0003;

    // Redirect out of HALT to the top word; next issue wraps to 0
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("wr_halted", 32'(halted), 32'd0);
    check("wr_addr", mem_read_address, 32'hFFFF_FFFC);
    step();
    check("wr_wrap", mem_read_address, 32'h0);
    step();
    check("wr_pc_top", instr_pc, 32'hFFFF_FFFC);
    check("wr_ins_top", instr, 32'h1300_007F);
    step();
    check("wr_pc0", instr_pc, 32'h0);
    check("wr_ins0", instr, 32'h0050_0093);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
